// File: rtl/kws_pkg.sv
// Shared types and constants for the keyword-spotting post-processing controller.
package kws_pkg;

    localparam int unsigned KWS_SCORE_W     = 16;
    localparam logic [2:0]  KWS_IDX_INVALID = 3'b111;

    typedef logic [KWS_SCORE_W-1:0] kws_score_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_READ,
        ST_DRAIN,
        ST_WAIT,
        ST_DECIDE
    } kws_state_e;

endpackage

// File: rtl/kws_post_ctrl_if.sv
// Score RAM read port plus post-block load/result port seen by the controller.
interface kws_post_ctrl_if
    import kws_pkg::*;
#(
    parameter int unsigned ADDR_W = 8
) ();

    logic              o_rd_en;
    logic [ADDR_W-1:0] o_rd_addr;
    kws_score_t        i_rd_data;
    logic              o_post_init;
    logic              o_post_we;
    kws_score_t        o_post_dout;
    kws_score_t        i_post_diff;
    logic [2:0]        i_post_idx;
    logic              i_post_validp;

    modport master (
        output o_rd_en, o_rd_addr, o_post_init, o_post_we, o_post_dout,
        input  i_rd_data, i_post_diff, i_post_idx, i_post_validp
    );

    modport slave (
        input  o_rd_en, o_rd_addr, o_post_init, o_post_we, o_post_dout,
        output i_rd_data, i_post_diff, i_post_idx, i_post_validp
    );

endinterface

// File: rtl/kws_vote.sv
// Confidence threshold, N-frame vote, post-detection hold timer and detection pulse.
module kws_vote
    import kws_pkg::*;
#(
    parameter int unsigned VOTE_N   = 3,
    parameter int unsigned HOLD_CYC = 1024
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       decide_i,
    input  logic       clr_i,
    input  logic [2:0] idx_i,
    input  kws_score_t diff_i,
    input  kws_score_t thresh_i,
    output logic       det_validp_o,
    output logic [2:0] det_idx_o,
    output logic       hold_o
);

    localparam int unsigned HOLD_W = $clog2(HOLD_CYC + 1);

    logic [3:0]        vote_q, vote_d;
    logic [2:0]        last_q;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              det_p_q, hold_flag_q;
    logic [2:0]        det_idx_q;
    logic              conf, fire;

    always_comb begin
        conf   = (idx_i != KWS_IDX_INVALID) && (diff_i >= thresh_i);
        vote_d = vote_q;
        if (clr_i) begin
            vote_d = '0;
        end else if (decide_i) begin
            if (conf && (idx_i == last_q))
                vote_d = (vote_q == 4'hF) ? 4'hF : vote_q + 4'd1;
            else
                vote_d = conf ? 4'd1 : 4'd0;
        end
        // Equality (not >=) so a run that keeps voting past VOTE_N stays silent.
        fire   = decide_i && (vote_d == 4'(VOTE_N)) && (hold_q == '0);
        hold_d = hold_q;
        if (fire)
            hold_d = HOLD_W'(HOLD_CYC);
        else if (hold_q != '0)
            hold_d = hold_q - 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vote_q      <= '0;
            last_q      <= KWS_IDX_INVALID;
            hold_q      <= '0;
            hold_flag_q <= 1'b0;
            det_p_q     <= 1'b0;
            det_idx_q   <= KWS_IDX_INVALID;
        end else begin
            vote_q      <= vote_d;
            hold_q      <= hold_d;
            hold_flag_q <= (hold_d != '0);
            det_p_q     <= fire;
            if (decide_i)
                last_q <= conf ? idx_i : KWS_IDX_INVALID;
            if (fire)
                det_idx_q <= idx_i;
        end
    end

    assign det_validp_o = det_p_q;
    assign det_idx_o    = det_idx_q;
    assign hold_o       = hold_flag_q;

endmodule

// File: rtl/kws_post_ctrl.sv
// Per-inference sequencer: clears the post block, streams class scores into it,
// waits for its result and hands the decision to the vote stage.
module kws_post_ctrl
    import kws_pkg::*;
#(
    parameter int unsigned NUM_CLASS = 7,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0,
    parameter int unsigned RD_LAT    = 1,
    parameter int unsigned VOTE_N    = 3,
    parameter int unsigned HOLD_CYC  = 1024,
    parameter int unsigned WAIT_TO   = 15
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   i_cnn_done,
    input  kws_score_t             i_thresh,
    kws_post_ctrl_if.master        bus,
    output logic                   o_busy,
    output logic                   o_det_validp,
    output logic [2:0]             o_det_idx,
    output logic                   o_hold,
    output logic                   o_err_p
);

    localparam int unsigned WT_W = (WAIT_TO < 2) ? 1 : $clog2(WAIT_TO);

    kws_state_e        state_q;
    logic [2:0]        cnt_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_en_q, post_init_q, post_we_q, busy_q, pend_q, err_p_q;
    logic [RD_LAT-1:0] dl_q;
    logic [WT_W-1:0]   wait_cnt_q;
    kws_score_t        dout_q, diff_q;
    logic [2:0]        idx_q;
    logic              decide, timeout;

    assign decide  = (state_q == ST_DECIDE);
    assign timeout = (state_q == ST_WAIT) && !bus.i_post_validp
                     && (wait_cnt_q == WT_W'(WAIT_TO - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rd_addr_q   <= ADDR_W'(BASE_ADDR);
            rd_en_q     <= 1'b0;
            post_init_q <= 1'b0;
            busy_q      <= 1'b0;
            pend_q      <= 1'b0;
            err_p_q     <= 1'b0;
            wait_cnt_q  <= '0;
            diff_q      <= '0;
            idx_q       <= KWS_IDX_INVALID;
        end else begin
            post_init_q <= 1'b0;
            err_p_q     <= timeout;
            // A single request may queue behind the running frame; a second one is an overrun.
            if ((state_q != ST_IDLE) && i_cnn_done) begin
                if (pend_q)
                    err_p_q <= 1'b1;
                else
                    pend_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (i_cnn_done || pend_q) begin
                        pend_q      <= pend_q && i_cnn_done;
                        post_init_q <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= ST_INIT;
                    end
                end
                ST_INIT: begin
                    cnt_q     <= '0;
                    rd_addr_q <= ADDR_W'(BASE_ADDR);
                    rd_en_q   <= 1'b1;
                    state_q   <= ST_READ;
                end
                ST_READ: begin
                    if (cnt_q == 3'(NUM_CLASS - 1)) begin
                        rd_en_q <= 1'b0;
                        state_q <= ST_DRAIN;
                    end else begin
                        cnt_q     <= cnt_q + 3'd1;
                        rd_addr_q <= rd_addr_q + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    if (dl_q == '0) begin
                        wait_cnt_q <= '0;
                        state_q    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (bus.i_post_validp) begin
                        diff_q  <= bus.i_post_diff;
                        idx_q   <= bus.i_post_idx;
                        state_q <= ST_DECIDE;
                    end else if (timeout) begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 1'b1;
                    end
                end
                ST_DECIDE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dl_q      <= '0;
            post_we_q <= 1'b0;
            dout_q    <= '0;
        end else begin
            dl_q[0] <= rd_en_q;
            for (int unsigned k = 1; k < RD_LAT; k++)
                dl_q[k] <= dl_q[k-1];
            post_we_q <= dl_q[RD_LAT-1];
            if (dl_q[RD_LAT-1])
                dout_q <= bus.i_rd_data;
        end
    end

    kws_vote #(
        .VOTE_N   (VOTE_N),
        .HOLD_CYC (HOLD_CYC)
    ) u_vote (
        .clk          (clk),
        .resetn       (resetn),
        .decide_i     (decide),
        .clr_i        (timeout),
        .idx_i        (idx_q),
        .diff_i       (diff_q),
        .thresh_i     (i_thresh),
        .det_validp_o (o_det_validp),
        .det_idx_o    (o_det_idx),
        .hold_o       (o_hold)
    );

    assign bus.o_rd_en     = rd_en_q;
    assign bus.o_rd_addr   = rd_addr_q;
    assign bus.o_post_init = post_init_q;
    assign bus.o_post_we   = post_we_q;
    assign bus.o_post_dout = dout_q;
    assign o_busy          = busy_q;
    assign o_err_p         = err_p_q;

endmodule

// File: tb/tb_kws_post_ctrl.sv
// Scoreboard bench: RAM and post-block stubs around two controllers (RD_LAT 1 and 3).
module tb_kws_post_ctrl;
    import kws_pkg::*;

    localparam int unsigned NC = 7, AW = 8, BASE = 252, VN = 3, HC = 40, WT = 15;
    typedef logic [15:0] frame_t [NC];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, rstn3, done, done3, stub_mute, stray;
    logic [15:0] thresh;
    logic        busy, detv, hold, errp, busy3, detv3, hold3, errp3;
    logic [2:0]  detidx, detidx3;

    kws_post_ctrl_if #(.ADDR_W(AW)) bus  ();
    kws_post_ctrl_if #(.ADDR_W(AW)) bus3 ();

    kws_post_ctrl #(
        .NUM_CLASS(NC), .ADDR_W(AW), .BASE_ADDR(BASE), .RD_LAT(1),
        .VOTE_N(VN), .HOLD_CYC(HC), .WAIT_TO(WT)
    ) dut (
        .clk(clk), .resetn(rstn), .i_cnn_done(done), .i_thresh(thresh), .bus(bus),
        .o_busy(busy), .o_det_validp(detv), .o_det_idx(detidx), .o_hold(hold), .o_err_p(errp)
    );

    kws_post_ctrl #(
        .NUM_CLASS(NC), .ADDR_W(AW), .BASE_ADDR(0), .RD_LAT(3),
        .VOTE_N(VN), .HOLD_CYC(HC), .WAIT_TO(WT)
    ) dut3 (
        .clk(clk), .resetn(rstn3), .i_cnn_done(done3), .i_thresh(thresh), .bus(bus3),
        .o_busy(busy3), .o_det_validp(detv3), .o_det_idx(detidx3), .o_hold(hold3), .o_err_p(errp3)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    endtask

    // RAM models and post-block stubs
    logic [15:0] ram [256];
    logic [15:0] ram3 [256];
    logic [15:0] p1, p2;
    logic [15:0] stub_diff = '0;
    logic [2:0]  stub_idx  = 3'b111;
    int st_cnt = 0, st3_cnt = 0;

    always @(posedge clk) bus.i_rd_data <= ram[bus.o_rd_addr];
    always @(posedge clk) begin
        p1 <= ram3[bus3.o_rd_addr];
        p2 <= p1;
        bus3.i_rd_data <= p2;
    end

    assign bus.i_post_diff  = stub_diff;
    assign bus.i_post_idx   = stub_idx;
    assign bus3.i_post_diff = '0;
    assign bus3.i_post_idx  = 3'b111;

    always @(posedge clk) begin
        bus.i_post_validp <= stray;
        if (bus.o_post_init) st_cnt <= 0;
        else if (bus.o_post_we) st_cnt <= st_cnt + 1;
        else if (st_cnt == NC) begin
            st_cnt <= 0;
            if (!stub_mute) bus.i_post_validp <= 1'b1;
        end
    end

    always @(posedge clk) begin
        bus3.i_post_validp <= 1'b0;
        if (bus3.o_post_init) st3_cnt <= 0;
        else if (bus3.o_post_we) st3_cnt <= st3_cnt + 1;
        else if (st3_cnt == NC) begin
            st3_cnt <= 0;
            bus3.i_post_validp <= 1'b1;
        end
    end

    // Scoreboard and monitors
    logic [15:0] exp_sc [$];
    logic [15:0] exp_sc3 [$];
    logic [2:0]  exp_det [$];
    int cyc = 0, n_init = 0, n_we = 0, n_err = 0, n_det = 0, last_we_cyc = 0, err_cyc = 0;
    int hold_run = 0, hold_len = 0, hold_left = 0;
    int n_we3 = 0, rd3_rise = 0, we3_rise = 0;
    logic err_busy = 1'b0, rd3_prev = 1'b0, we3_prev = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (bus.o_post_init) n_init <= n_init + 1;
        if (bus.o_post_we) begin
            n_we <= n_we + 1;
            last_we_cyc <= cyc;
            chk("we_expected", exp_sc.size() != 0, 1);
            if (exp_sc.size() != 0) chk("we_data", bus.o_post_dout, exp_sc.pop_front());
        end
        if (errp) begin
            n_err <= n_err + 1;
            err_cyc <= cyc;
            err_busy <= busy;
        end
        if (detv) begin
            n_det <= n_det + 1;
            chk("det_hold", hold, 1);
            chk("det_expected", exp_det.size() != 0, 1);
            if (exp_det.size() != 0) chk("det_idx", detidx, exp_det.pop_front());
        end
        hold_left <= detv ? HC : ((hold_left > 0) ? hold_left - 1 : 0);
        if (hold) hold_run <= hold_run + 1;
        else if (hold_run != 0) begin
            hold_len <= hold_run;
            hold_run <= 0;
        end
        if (bus3.o_post_we) begin
            n_we3 <= n_we3 + 1;
            chk("we3_expected", exp_sc3.size() != 0, 1);
            if (exp_sc3.size() != 0) chk("we3_data", bus3.o_post_dout, exp_sc3.pop_front());
        end
        if (bus3.o_rd_en && !rd3_prev) rd3_rise <= cyc;
        if (bus3.o_post_we && !we3_prev) we3_rise <= cyc;
        rd3_prev <= bus3.o_rd_en;
        we3_prev <= bus3.o_post_we;
    end

    // Reference vote model
    int         m_vote = 0;
    logic [2:0] m_last = 3'b111;

    task automatic predict(input logic [2:0] idx, input logic [15:0] diff);
        bit conf;
        conf = (idx != 3'b111) && (diff >= thresh);
        if (conf && idx == m_last) m_vote = (m_vote >= 15) ? 15 : m_vote + 1;
        else m_vote = conf ? 1 : 0;
        m_last = conf ? idx : 3'b111;
        if (m_vote == VN && hold_left == 0) exp_det.push_back(idx);
    endtask

    task automatic load_frame(input frame_t s);
        int mi, si;
        mi = 0;
        for (int k = 0; k < NC; k++) begin
            ram[8'(BASE + k)] = s[k];
            if ($signed(s[k]) > $signed(s[mi])) mi = k;
        end
        si = (mi == 0) ? 1 : 0;
        for (int k = 0; k < NC; k++)
            if (k != mi && $signed(s[k]) > $signed(s[si])) si = k;
        if ($signed(s[mi]) < 0) begin
            stub_idx  = 3'b111;
            stub_diff = '0;
        end else begin
            stub_idx  = 3'(mi);
            stub_diff = s[mi] - s[si];
        end
    endtask

    task automatic push_scores(input frame_t s);
        for (int k = 0; k < NC; k++) exp_sc.push_back(s[k]);
    endtask

    task automatic pulse_done();
        @(posedge clk); #1 done = 1'b1;
        @(posedge clk); #1 done = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("frame_end", busy, 0);
        @(negedge clk);
    endtask

    task automatic run_frame(input frame_t s);
        load_frame(s);
        predict(stub_idx, stub_diff);
        push_scores(s);
        pulse_done();
        wait_idle();
    endtask

    frame_t fa, fb, fn;
    int i0, e0, w0, gap;

    initial begin
        fa = '{16'd5, 16'd900, 16'd20, 16'd30, 16'd10, 16'd0, 16'd40};
        fb = '{16'd5, 16'd10, 16'd900, 16'd30, 16'd10, 16'd0, 16'd40};
        fn = '{16'h8000, 16'h8001, 16'h8002, 16'h8003, 16'h8004, 16'h8005, 16'h8006};
        for (int k = 0; k < 256; k++) begin
            ram[k]  = 16'h0;
            ram3[k] = 16'h0;
        end
        rstn = 1'b0; rstn3 = 1'b0; done = 1'b0; done3 = 1'b0;
        stub_mute = 1'b0; stray = 1'b0; thresh = 16'd100;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_det", detv, 0);
        chk("rst_det_idx", detidx, 3'b111);
        chk("rst_hold", hold, 0);
        chk("rst_err", errp, 0);
        chk("rst_rd_en", bus.o_rd_en, 0);
        chk("rst_rd_addr", bus.o_rd_addr, BASE);
        chk("rst_init", bus.o_post_init, 0);
        chk("rst_we", bus.o_post_we, 0);
        chk("rst_dout", bus.o_post_dout, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // single frame: scores streamed in order, captured result, first vote
        i0 = n_init; w0 = n_we;
        run_frame(fa);
        chk("f1_init", n_init - i0, 1);
        chk("f1_we", n_we - w0, NC);
        chk("f1_idx", dut.idx_q, 1);
        chk("f1_diff", dut.diff_q, 860);
        chk("f1_vote", dut.u_vote.vote_q, m_vote);
        chk("f1_nodet", n_det, 0);

        // three identical confident frames fire once; a fourth does not
        run_frame(fa);
        run_frame(fa);
        chk("f3_det", n_det, 1);
        chk("f3_det_idx", detidx, 1);
        run_frame(fa);
        chk("f4_nodet", n_det, 1);
        for (int i = 0; i < 200 && hold; i++) @(negedge clk);
        @(negedge clk);
        chk("hold_fall", hold, 0);
        chk("hold_len", hold_len, HC);

        // 1,1,2,2,2 detects idx 2 once; then an all-negative frame
        run_frame(fa);
        run_frame(fa);
        run_frame(fb);
        run_frame(fb);
        chk("seq_nodet", n_det, 1);
        run_frame(fb);
        chk("seq_det", n_det, 2);
        chk("seq_det_idx", detidx, 2);
        run_frame(fn);
        chk("neg_vote", dut.u_vote.vote_q, 0);
        chk("neg_last", dut.u_vote.last_q, 3'b111);

        // result pulse outside WAIT is ignored
        @(posedge clk); #1 stray = 1'b1;
        @(posedge clk); #1 stray = 1'b0;
        repeat (3) @(negedge clk);
        chk("stray_busy", busy, 0);
        chk("stray_vote", dut.u_vote.vote_q, m_vote);

        // pending request during READ, overrun on a third request
        thresh = 16'hFFFF;
        load_frame(fa);
        predict(stub_idx, stub_diff);
        predict(stub_idx, stub_diff);
        push_scores(fa);
        push_scores(fa);
        i0 = n_init; e0 = n_err;
        pulse_done();
        for (int i = 0; i < 20 && !bus.o_rd_en; i++) @(negedge clk);
        pulse_done();
        pulse_done();
        for (int i = 0; i < 100 && busy; i++) @(negedge clk);
        gap = 0;
        while (!busy && gap < 10) begin
            gap++;
            @(negedge clk);
        end
        chk("pend_gap", gap, 1);
        chk("pend_init", bus.o_post_init, 1);
        wait_idle();
        chk("pend_frames", n_init - i0, 2);
        chk("overrun_err", n_err - e0, 1);

        // post-block timeout
        thresh = 16'd100;
        run_frame(fa);
        chk("to_pre_vote", dut.u_vote.vote_q, 1);
        stub_mute = 1'b1;
        e0 = n_err;
        load_frame(fa);
        push_scores(fa);
        m_vote = 0;
        pulse_done();
        wait_idle();
        chk("to_err", n_err - e0, 1);
        chk("to_latency", err_cyc - last_we_cyc, WT + 1);
        chk("to_idle", err_busy, 0);
        chk("to_vote", dut.u_vote.vote_q, 0);
        stub_mute = 1'b0;

        // RD_LAT=3: reset mid-READ, then a clean frame
        for (int k = 0; k < NC; k++) begin
            ram3[k] = fa[k];
            exp_sc3.push_back(fa[k]);
        end
        rstn3 = 1'b1;
        repeat (2) @(negedge clk);
        @(posedge clk); #1 done3 = 1'b1;
        @(posedge clk); #1 done3 = 1'b0;
        for (int i = 0; i < 20 && !bus3.o_rd_en; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("rl3_dout_pre", bus3.o_post_dout, 900);
        rstn3 = 1'b0;
        #1;
        chk("rl3_rst_rd_en", bus3.o_rd_en, 0);
        chk("rl3_rst_addr", bus3.o_rd_addr, 0);
        chk("rl3_rst_we", bus3.o_post_we, 0);
        chk("rl3_rst_dout", bus3.o_post_dout, 0);
        chk("rl3_rst_init", bus3.o_post_init, 0);
        chk("rl3_rst_busy", busy3, 0);
        chk("rl3_rst_det", {detv3, detidx3, hold3, errp3}, 6'b0_111_0_0);
        exp_sc3.delete();
        repeat (2) @(negedge clk);
        rstn3 = 1'b1;
        repeat (2) @(negedge clk);
        w0 = n_we3;
        for (int k = 0; k < NC; k++) exp_sc3.push_back(fa[k]);
        @(posedge clk); #1 done3 = 1'b1;
        @(posedge clk); #1 done3 = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (!busy3) break;
        end
        @(negedge clk);
        chk("rl3_end", busy3, 0);
        chk("rl3_we_cnt", n_we3 - w0, NC);
        chk("rl3_first_we", we3_rise - rd3_rise, 4);
        chk("rl3_q_empty", exp_sc3.size(), 0);

        chk("sc_empty", exp_sc.size(), 0);
        chk("det_q_empty", exp_det.size(), 0);
        chk("det_total", n_det, 2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
